// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel output driver with a shared prescaled 255-tick PWM counter.
// Define PWM_SHADOW_EN to latch the duty only at period boundaries; otherwise the duty applies on the next clk.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam logic [15:0] PRE_MAX = 16'(CLK_DIV - 1);

    logic [15:0] r_pre_cnt;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  w_duty_active;
    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;
    logic        w_tick;
    logic        w_pwm_level;

    assign w_tick   = r_pre_cnt == PRE_MAX;
    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // The PWM counter wraps at 254 so a period is exactly 255 ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 16'd1;
            if (w_tick)
                r_pwm_cnt <= (r_pwm_cnt == 8'd254) ? '0 : r_pwm_cnt + 8'd1;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] r_duty_active;
    logic       r_first;
    logic       w_wrap;

    assign w_wrap = w_tick && (r_pwm_cnt == 8'd254);

    // The first clk after reset uses the live duty so the opening period is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active <= '0;
            r_first       <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_first || w_wrap)
                r_duty_active <= pwm_duty_cycle;
        end
    end

    assign w_duty_active = r_first ? pwm_duty_cycle : r_duty_active;
`else
    assign w_duty_active = pwm_duty_cycle;
`endif

    assign w_pwm_level = (w_duty_active == 8'd255) || (r_pwm_cnt < w_duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= w_en_out & (~w_en_pwm | {16{w_pwm_level}});
            period_start <= (r_pre_cnt == 16'd0) && (r_pwm_cnt == 8'd0);
        end
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: randomized and directed checks of pwm_peripheral against a cycle-count model.
module tb_pwm_peripheral;
    localparam int D = 4;
    localparam int P = 255 * D;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] out;
    logic        period_start;
    int          tests = 0;
    int          fails = 0;

    pwm_peripheral #(.CLK_DIV(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]),
        .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]),
        .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty),
        .out(out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Reference: m_c counts clks since reset release; position in period and tick follow by division.
    int          m_c;
    logic [15:0] m_out;
    logic        m_ps;
    logic [7:0]  m_pd;
    logic [7:0]  m_d;

    assign m_d = (SHADOW && m_c != 0) ? m_pd : duty;

    function automatic logic [15:0] model_out(int c, logic [7:0] d, logic [15:0] eo, logic [15:0] ep);
        int k = (c % P) / D;
        logic lvl = k < int'(d);
        return eo & (~ep | {16{lvl}});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c   <= 0;
            m_out <= '0;
            m_ps  <= 1'b0;
            m_pd  <= '0;
        end else begin
            m_out <= model_out(m_c, m_d, en_out, en_pwm);
            m_ps  <= (m_c % P) == 0;
            if (m_c == 0 || (m_c % P) == P - 1)
                m_pd <= duty;
            m_c <= m_c + 1;
        end
    end

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        duty   = 8'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (out !== 16'h0000) begin fails++; $display("FAIL reset_out got=%h exp=0000", out); end
        tests++;
        if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps got=%b exp=0", period_start); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (period_start !== 1'b1) begin fails++; $display("FAIL first_ps got=%b exp=1", period_start); end
        tests++;
        if (out !== 16'hFFFF) begin fails++; $display("FAIL first_out got=%h exp=FFFF", out); end
        @(negedge clk);
        tests++;
        if (period_start !== 1'b0) begin fails++; $display("FAIL ps_width got=%b exp=0", period_start); end
    endtask

    task automatic test_static;
        en_out = 16'h0000;
        en_pwm = 16'hFFFF;
        @(negedge clk);
        tests++;
        if (out !== 16'h0000) begin fails++; $display("FAIL static_off got=%h exp=0000", out); end
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        @(negedge clk);
        tests++;
        if (out !== 16'hFFFF) begin fails++; $display("FAIL static_on got=%h exp=FFFF", out); end
        en_out = 16'h0000;
        @(negedge clk);
        tests++;
        if (out !== 16'h0000) begin fails++; $display("FAIL static_drop got=%h exp=0000", out); end
    endtask

    task automatic test_duty_128;
        bit ok1, ok2;
        int hi = 0, lo = 0, upper = 0, bad = 0;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'd128;
        wait_ps(ok1);
        wait_ps(ok2);
        tests++;
        if (!(ok1 && ok2)) begin fails++; $display("FAIL d128_sync got=%b%b exp=11", ok1, ok2); end
        for (int j = 0; j < P; j++) begin
            if (j > 0) @(negedge clk);
            if (out[0]) hi++; else lo++;
            if (out[15:1] != 15'd0) upper++;
            if (out !== m_out || period_start !== m_ps) bad++;
        end
        tests++;
        if (hi != 128 * D) begin fails++; $display("FAIL d128_high got=%0d exp=%0d", hi, 128 * D); end
        tests++;
        if (lo != 127 * D) begin fails++; $display("FAIL d128_low got=%0d exp=%0d", lo, 127 * D); end
        tests++;
        if (upper != 0) begin fails++; $display("FAIL d128_upper got=%0d exp=0", upper); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL d128_model got=%0d exp=0", bad); end
    endtask

    task automatic test_extremes;
        bit ok1, ok2;
        int hi, lo, edges;
        logic prev;
        en_out = 16'h0008;
        en_pwm = 16'h0008;
        for (int pass = 0; pass < 2; pass++) begin
            duty = (pass == 0) ? 8'd0 : 8'd255;
            wait_ps(ok1);
            wait_ps(ok2);
            tests++;
            if (!(ok1 && ok2)) begin fails++; $display("FAIL ext_sync pass=%0d got=%b%b exp=11", pass, ok1, ok2); end
            hi = 0;
            lo = 0;
            edges = 0;
            prev = out[3];
            for (int j = 0; j < 2 * P; j++) begin
                if (j > 0) @(negedge clk);
                if (out[3]) hi++; else lo++;
                if (out[3] !== prev) edges++;
                prev = out[3];
            end
            tests++;
            if ((pass == 0 ? hi : lo) != 0) begin
                fails++;
                $display("FAIL ext_level pass=%0d got_hi=%0d got_lo=%0d exp_other=0", pass, hi, lo);
            end
            tests++;
            if (edges != 0) begin fails++; $display("FAIL ext_edges pass=%0d got=%0d exp=0", pass, edges); end
        end
    endtask

    task automatic test_duty_change;
        bit ok1, ok2;
        int hi1 = 0, hi2 = 0, bad = 0;
        int exp1 = SHADOW ? 64 * D : 156 * D;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'd64;
        wait_ps(ok1);
        wait_ps(ok2);
        tests++;
        if (!(ok1 && ok2)) begin fails++; $display("FAIL chg_sync got=%b%b exp=11", ok1, ok2); end
        for (int j = 0; j < 2 * P; j++) begin
            if (j > 0) @(negedge clk);
            if (j < P) hi1 += int'(out[0]); else hi2 += int'(out[0]);
            if (out !== m_out || period_start !== m_ps) bad++;
            // Changing during the last clk of tick 99 makes tick 100 the first one to see the new duty.
            if (j == 100 * D - 1) duty = 8'd192;
        end
        tests++;
        if (hi1 != exp1) begin fails++; $display("FAIL chg_current got=%0d exp=%0d", hi1, exp1); end
        tests++;
        if (hi2 != 192 * D) begin fails++; $display("FAIL chg_next got=%0d exp=%0d", hi2, 192 * D); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL chg_model got=%0d exp=0", bad); end
    endtask

    task automatic test_random;
        int n;
        for (int seg = 0; seg < 25; seg++) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            duty   = 8'($urandom);
            if (seg % 5 == 0) duty = (seg % 10 == 0) ? 8'd0 : 8'd255;
            n = $urandom_range(30, 600);
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                tests++;
                if (out !== m_out || period_start !== m_ps) begin
                    fails++;
                    $display("FAIL rand seg=%0d c=%0d out=%h exp=%h ps=%b exp_ps=%b", seg, m_c, out, m_out, period_start, m_ps);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n = 0;
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        duty   = 8'd100;
        wait_ps(ok);
        repeat (300) @(negedge clk);
        tests++;
        if (!ok || out !== 16'hFFFF) begin fails++; $display("FAIL rst_pre got=%h ok=%b exp=FFFF", out, ok); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 16'h0000) begin fails++; $display("FAIL rst_async got=%h exp=0000", out); end
        en_pwm = 16'hFFFF;
        repeat (3) @(negedge clk);
        tests++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold got=%h ps=%b exp=0000 0", out, period_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (period_start !== 1'b1) begin fails++; $display("FAIL rst_first_ps got=%b exp=1", period_start); end
        for (int i = 0; i < P + 5; i++) begin
            @(negedge clk);
            n++;
            if (period_start === 1'b1) break;
        end
        tests++;
        if (n != P) begin fails++; $display("FAIL rst_period got=%0d exp=%0d", n, P); end
    endtask

    initial begin
        test_reset;
        test_static;
        test_duty_128;
        test_extremes;
        test_duty_change;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
